register_file_16x16: RTL
========================

# register_file_16x16

Sixteen-entry, 16-bit general-purpose register file for the 16-bit processor. It is the direct consumer of the 4-bit 2:1 destination-select mux: that mux's 4-bit output drives `WrAddr`. The block provides two asynchronous read ports, one synchronous write port, a hardwired-zero R0, and write-through bypass, so the execute stage sees a same-cycle write without a stall.

## Interface
- `DATA_W`, 16, register width in bits
- `ADDR_W`, 4, register index width; the block has 2**ADDR_W registers
- `Clk` input 1: single clock; all state updates on the rising edge
- `Reset` input 1: asynchronous, active-high; clears all registers
- `WrEn` input 1: write enable, sampled on the rising edge of `Clk`
- `WrAddr` input ADDR_W: destination register index, driven by the 4-bit destination-select mux
- `WrData` input DATA_W: write-back value
- `RdAddrA` input ADDR_W: read port A index (rs)
- `RdAddrB` input ADDR_W: read port B index (rt)
- `RdDataA` output DATA_W: read port A data
- `RdDataB` output DATA_W: read port B data
- `WrAck` output 1: registered pulse, high for one cycle after a write that was accepted

## Operation
- Storage is registers R1–R15. R0 has no storage and always reads 0x0000.
- Write: on a rising `Clk` with `WrEn`=1, `WrAddr`≠0 and `Reset`=0, R[WrAddr] is loaded with `WrData`.
  - A write to R0 is discarded, and `WrAck` stays 0 for it.
- Read: `RdDataX` is combinational from `RdAddrX`.
- Read bypass: if `WrEn`=1, `WrAddr`=`RdAddrX`, `WrAddr`≠0 and `Reset`=0, then `RdDataX` = `WrData` in the same cycle. Otherwise `RdDataX` = R[RdAddrX].
- Both ports may address the same register, and both may bypass at the same time.
- `Reset`=1 has these effects, asynchronously and for the whole time it is asserted:
  - R1–R15 are cleared to 0x0000 and `WrAck` is cleared to 0.
  - Bypass is suppressed, so both read ports return 0x0000.
  - Writes are ignored.
- Reset deasserted on the same edge as a write: the write is taken only if `Reset` is already low at that edge. If `Reset` is still high, the write is lost.
- Any X or Z on `WrAddr` while `WrEn`=1 is a protocol violation. The simulation assertion flags it.

## Timing
- Write latency: data is stored at rising edge N and is visible from storage after edge N. The bypass makes it visible to readers during cycle N, before the edge.
- Read latency: 0 cycles, combinational. The path is address → mux → data, plus the bypass compare. It must close within one cycle at the processor clock, together with the upstream destination mux.
- `WrAck`:
  - Goes high for exactly one cycle after edge N when the write at edge N was accepted.
  - Back-to-back accepted writes hold `WrAck` high continuously.
- Reset values: R1–R15 = 0x0000, `WrAck` = 0, `RdDataA` = `RdDataB` = 0x0000.
- There is no other state: no FSM, no counters beyond the register array.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W`, `ADDR_W` and `NUM_REGS` (= 16)
  - `ZERO_REG` (= 4'd0)
  - typedef `reg_idx_t` (logic [ADDR_W-1:0])
  - typedef `word_t` (logic [DATA_W-1:0])
- Sub-module `regfile_read_port`: one 16:1 read mux with R0 forcing and the bypass compare. It is instantiated twice, for A and B.
- Top level holds:
  - the register array
  - the write decode
  - the `WrAck` flop
  - the X-check assertion

## Test plan
- Reset mid-operation: load R5=0x1234, assert `Reset` asynchronously between edges → all reads return 0x0000 immediately; `WrAck`=0; after release, R5 reads 0x0000.
- Basic write/read: write R3=0xBEEF at edge 1, then read `RdAddrA`=3 in cycle 2 → `RdDataA`=0xBEEF; `WrAck`=1 in cycle 2 only.
- R0 protection: `WrEn`=1, `WrAddr`=0, `WrData`=0xFFFF → both ports read 0x0000 at address 0, with and without the bypass condition; `WrAck` stays 0.
- Bypass, both ports: R7=0x0001 stored, then `WrEn`=1, `WrAddr`=7, `WrData`=0xA5A5 with `RdAddrA`=`RdAddrB`=7 → both ports show 0xA5A5 in the same cycle; after the edge, storage reads 0xA5A5.
- Sweep: write R1–R15 with value 0x1000+i on consecutive edges, then read all pairs (i, 16−i) → exact values; `WrAck` high for 15 consecutive cycles.
- Write/reset race: release `Reset` one cycle before vs. on the same edge as a write to R9=0x5555 → taken in the first case, lost (R9=0x0000) in the second.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and types for the 16-bit processor datapath.
// Register index and word types used by the register file.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t ZERO_REG = 4'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous register-file read port.
// R0 reads zero; a same-cycle write to the read index bypasses storage.
module regfile_read_port
  import cpu_pkg::*;
(
  input  logic     rst,
  input  logic     wr_en,
  input  reg_idx_t wr_addr,
  input  word_t    wr_data,
  input  reg_idx_t rd_addr,
  input  word_t    regs [NUM_REGS],
  output word_t    rd_data
);

  logic is_zero;
  logic hit;

  assign is_zero = (rd_addr == ZERO_REG);
  assign hit     = wr_en && !rst
                && (wr_addr == rd_addr)
                && (wr_addr != ZERO_REG);

  // Select zero, bypassed write data, or stored word
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      is_zero: rd_data = '0;
      hit:     rd_data = wr_data;
      default: rd_data = regs[rd_addr];
    endcase
  end

endmodule

// File: rtl/register_file_16x16.sv
// 16 x 16-bit register file: two async reads, one sync write,
// hardwired-zero R0, write-through bypass and a write-ack pulse.
module register_file_16x16
  import cpu_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataA,
  output logic [DATA_W-1:0] RdDataB,
  output logic              WrAck
);

  word_t regs [NUM_REGS];
  logic  wr_acc;

  assign wr_acc = WrEn && (WrAddr != ZERO_REG);

  // Store accepted writes; entry 0 is never written and stays zero
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_acc) begin
      regs[WrAddr] <= WrData;
    end
  end

  // One-cycle acknowledge after each accepted write
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      WrAck <= 1'b0;
    else
      WrAck <= wr_acc;
  end

  regfile_read_port u_port_a (
    .rst     (Reset),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .rd_addr (RdAddrA),
    .regs    (regs),
    .rd_data (RdDataA)
  );

  regfile_read_port u_port_b (
    .rst     (Reset),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .rd_addr (RdAddrB),
    .regs    (regs),
    .rd_data (RdDataB)
  );

  a_wraddr_known: assert property (
    @(posedge Clk) disable iff (Reset)
    WrEn |-> !$isunknown(WrAddr)
  ) else $error("WrAddr unknown while WrEn=1");

endmodule
